// File: rtl/d_ip_timer_cfg_seq.sv
// Programs a timer's count-config registers with a 7-write sequence, optionally reading back and
// checking six of them; arbitrates the timer register port between the sequencer and a host.
module d_ip_timer_cfg_seq #(
  parameter logic [5:0] ADDR_CTRL = 6'h00,
  parameter logic [5:0] ADDR_INIT = 6'h04,
  parameter logic [5:0] ADDR_MIN  = 6'h05,
  parameter logic [5:0] ADDR_MAX  = 6'h06,
  parameter logic [5:0] ADDR_M0   = 6'h08,
  parameter logic [5:0] ADDR_M1   = 6'h09,
  parameter logic [7:0] EN_MASK   = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       verify_en,
  input  logic [7:0] cfg_ctrl,
  input  logic [7:0] cfg_init,
  input  logic [7:0] cfg_min,
  input  logic [7:0] cfg_max,
  input  logic [7:0] cfg_m0,
  input  logic [7:0] cfg_m1,
  input  logic       host_req,
  input  logic [5:0] host_addr,
  input  logic       host_wr_en,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic [7:0] host_rdata,
  output logic [5:0] tmr_addr,
  output logic       tmr_wr_en,
  output logic [7:0] tmr_wdata,
  output logic       tmr_mod_en,
  input  logic [7:0] tmr_rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_idx
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CHK, S_DONE, S_ERR} state_t;

  state_t     state;
  logic [2:0] step;
  logic       verify_q;
  logic [7:0] ctrl_q, init_q, min_q, max_q, m0_q, m1_q;
  logic [5:0] step_addr;
  logic [7:0] step_data;
  logic       idle_type;
  logic       accept;

  // Step 0 writes CTRL with the enable cleared so the counter stays stopped while configured.
  always_comb begin
    step_addr = ADDR_CTRL;
    step_data = ctrl_q & ~EN_MASK;
    case (step)
      3'd1: begin step_addr = ADDR_INIT; step_data = init_q; end
      3'd2: begin step_addr = ADDR_MIN;  step_data = min_q;  end
      3'd3: begin step_addr = ADDR_MAX;  step_data = max_q;  end
      3'd4: begin step_addr = ADDR_M0;   step_data = m0_q;   end
      3'd5: begin step_addr = ADDR_M1;   step_data = m1_q;   end
      3'd6: begin step_addr = ADDR_CTRL; step_data = ctrl_q; end
      default: ;
    endcase
  end

  assign idle_type  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign accept     = idle_type && start;
  assign busy       = (state == S_WR) || (state == S_RD) || (state == S_CHK);
  assign host_gnt   = !rst && host_req && !busy && !accept;
  assign host_rdata = tmr_rdata;

  always_comb begin
    tmr_addr   = '0;
    tmr_wr_en  = 1'b0;
    tmr_wdata  = '0;
    tmr_mod_en = 1'b0;
    if (host_gnt) begin
      tmr_addr   = host_addr;
      tmr_wr_en  = host_wr_en;
      tmr_wdata  = host_wdata;
      tmr_mod_en = 1'b1;
    end else if (!rst && state == S_WR) begin
      tmr_addr   = step_addr;
      tmr_wr_en  = 1'b1;
      tmr_wdata  = step_data;
      tmr_mod_en = 1'b1;
    end else if (!rst && state == S_RD) begin
      tmr_addr   = step_addr;
      tmr_mod_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      step     <= '0;
      verify_q <= 1'b0;
      ctrl_q   <= '0;
      init_q   <= '0;
      min_q    <= '0;
      max_q    <= '0;
      m0_q     <= '0;
      m1_q     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
    end else begin
      case (state)
        S_WR: begin
          if (step == 3'd6) begin
            if (verify_q) begin
              state <= S_RD;
              step  <= 3'd1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            step <= step + 3'd1;
          end
        end
        S_RD: state <= S_CHK;
        // Timer read data is registered, so it lines up with the step still held from RD.
        S_CHK: begin
          if (tmr_rdata != step_data) begin
            state   <= S_ERR;
            err     <= 1'b1;
            err_idx <= step;
          end else if (step == 3'd6) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            step  <= step + 3'd1;
            state <= S_RD;
          end
        end
        default: begin
          if (start) begin
            state    <= S_WR;
            step     <= '0;
            verify_q <= verify_en;
            ctrl_q   <= cfg_ctrl;
            init_q   <= cfg_init;
            min_q    <= cfg_min;
            max_q    <= cfg_max;
            m0_q     <= cfg_m0;
            m1_q     <= cfg_m1;
            done     <= 1'b0;
            err      <= 1'b0;
            err_idx  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/d_ip_timer_cfg_seq.md
D_IP_TIMER_CFG_SEQ -- requirements
Module: d_ip_timer_cfg_seq

Interface
REQ-001 SHALL have parameter ADDR_CTRL, default 6'h00, CTRL register address.
REQ-002 SHALL have parameters ADDR_INIT/ADDR_MIN/ADDR_MAX/ADDR_M0/ADDR_M1, defaults 6'h04/6'h05/6'h06/6'h08/6'h09, count-config register addresses.
REQ-003 SHALL have parameter EN_MASK, default 8'h01, CTRL enable bit(s).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin configuration sequence
- verify_en  in  1  enable readback check, sampled with start
- cfg_ctrl, cfg_init, cfg_min, cfg_max, cfg_m0, cfg_m1  in  8 each  values to program, sampled with start
- host_req  in  1  host access request
- host_addr  in  6  host address
- host_wr_en  in  1  host write
- host_wdata  in  8  host write data
- host_gnt  out  1  host owns timer port this cycle
- host_rdata  out  8  equals tmr_rdata
- tmr_addr  out  6  timer register address
- tmr_wr_en  out  1  timer write strobe
- tmr_wdata  out  8  timer write data
- tmr_mod_en  out  1  timer access enable
- tmr_rdata  in  8  timer read data, valid the cycle after address
- busy  out  1  sequence in progress
- done  out  1  sticky, sequence passed
- err  out  1  sticky, readback mismatch
- err_idx  out  3  step index of first mismatch

Function
REQ-005 SHALL implement FSM states IDLE, WR, RD, CHK, DONE, ERR.
REQ-006 SHALL, in IDLE/DONE/ERR with start=1, capture cfg_* and verify_en, clear done/err/err_idx, go to WR with step=0.
REQ-007 SHALL ignore start while busy.
REQ-008 SHALL, in WR, issue one write per cycle (tmr_wr_en=1, tmr_mod_en=1), steps 0..6: CTRL<=cfg_ctrl&~EN_MASK, INIT, MIN, MAX, M0, M1, CTRL<=cfg_ctrl.
REQ-009 SHALL, after step 6, go to DONE if captured verify_en=0, else to RD with step=1.
REQ-010 SHALL, in RD, drive step address with tmr_wr_en=0, tmr_mod_en=1, then go to CHK.
REQ-011 SHALL, in CHK, compare tmr_rdata to the step's written value; mismatch: err=1, err_idx=step, go to ERR; match and step=6: go to DONE; else step+1, back to RD.
REQ-012 SHALL make full write sequence 7 cycles and full verified sequence 7+12=19 cycles from start to DONE entry.
REQ-013 SHALL assert busy exactly in WR, RD, CHK.
REQ-014 SHALL assert host_gnt = host_req when not busy and not (state idle-type and start=1); start wins a same-cycle tie.
REQ-015 SHALL, when host_gnt=1, drive tmr_addr=host_addr, tmr_wr_en=host_wr_en, tmr_wdata=host_wdata, tmr_mod_en=1.
REQ-016 SHALL, when neither sequencer nor host owns the port, drive tmr_wr_en=0, tmr_mod_en=0, tmr_addr=0, tmr_wdata=0.
REQ-017 SHALL never pass a host write to the timer while busy (host_gnt=0).
REQ-018 SHALL hold done/err until the next accepted start or reset.

Reset
REQ-019 SHALL, on rst=1, asynchronously enter IDLE, step=0, all outputs 0 (host_rdata follows tmr_rdata).
REQ-020 SHALL, on rst mid-sequence, abandon the sequence with no further timer writes; done=0, err=0.

Verification
REQ-021 start, verify_en=0, cfg_ctrl=8'hA1, others 8'h10..8'h14 -> 7 writes in order, first CTRL=8'hA0, last CTRL=8'hA1, done=1 on cycle 8.
REQ-022 start, verify_en=1, model returns written values -> 6 read/check pairs, done=1 at cycle 20, err=0.
REQ-023 verify_en=1, model corrupts CNT_MAX readback -> err=1, err_idx=3, done=0, no further reads.
REQ-024 host_req held through sequence -> host_gnt=0 while busy, 1 the cycle after DONE; start+host_req same idle cycle -> host_gnt=0.
REQ-025 rst pulse during step 3 write -> outputs 0 immediately, IDLE, no writes until next start.
REQ-026 start pulses during busy -> ignored; sequence completes in nominal cycle count.
